mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one two_port_ram instance among NUM_REQ requesters (cores, DMA), serving up to two requests per cycle: one on port A, one on port B.
- Round-robin fairness.
- Blocks same-address hazards across the two ports.
- Routes the registered RAM read data back to the requester that issued the read.
- Sits between the core memory stages and the shared RAM.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, at least 2.
- address_length, 4, RAM address width.
- word_length, 64, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until granted.
- req_we  in  NUM_REQ  1 = write, 0 = read; stable while req is high.
- req_addr  in  NUM_REQ*address_length  requester i uses slice [i*address_length +: address_length].
- req_wdata  in  NUM_REQ*word_length  write data, sliced the same way as req_addr.
- gnt  out  NUM_REQ  combinational grant in the cycle the request is issued to RAM; at most two bits set.
- rsp_valid  out  NUM_REQ  registered; pulses for one cycle with read data.
- rsp_rdata  out  NUM_REQ*word_length  registered read data per requester; 0 when rsp_valid is low.
- ram_address_a, ram_address_b  out  address_length  to RAM.
- ram_data_a, ram_data_b  out  word_length  to RAM.
- ram_wren_a, ram_wren_b  out  1  to RAM.
- ram_q_a, ram_q_b  in  word_length  RAM outputs, registered inside RAM (1-cycle read latency).

Behaviour:
- State:
  - rr_ptr, $clog2(NUM_REQ) bits.
  - Response tags: vld_a/vld_b (1 bit each) and own_a/own_b (requester index each).
- Reset (sync, while reset=1):
  - gnt=0, ram_wren_a/b=0, ram_address_a/b=0, ram_data_a/b=0.
  - rr_ptr=0, vld_a=vld_b=0.
  - First cycle after reset deasserts: rsp_valid=0, rsp_rdata=0.
- Selection, combinational each cycle, with reset low:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - First pending req is winner A and drives port A.
  - Next pending req is candidate B.
  - Candidate B is granted on port B unless its address equals A's and either one is a write.
  - A conflicted candidate B is not granted. The scan continues to the next pending requester for port B under the same conflict rule.
  - Two reads to the same address are both granted.
  - Idle port: wren=0, address=0, data=0.
- Grant cycle T:
  - gnt[i]=1 and RAM port signals driven from requester i.
  - A write completes at the rising edge ending T; writes produce no response.
  - Requester drops or changes req after seeing gnt.
- Read response:
  - Rising edge ending T sets vld_x=1 and own_x=i for each port that carried a read.
  - In cycle T+1: rsp_valid[own_x]=1 and rsp_rdata slice own_x = ram_q_x.
  - A requester may be re-granted in T+1; at most one outstanding read per port per cycle.
- rr_ptr update:
  - After any grant: rr_ptr = (highest-priority-order index of last granted requester + 1) mod NUM_REQ.
  - After no grant: unchanged.
- Reset mid-operation:
  - Reads granted in the cycle reset rises are discarded: vld cleared, no rsp_valid.
  - A write presented in that cycle is suppressed, since gnt/wren are forced 0 during reset.
- Single requester: always port A; port B idle.
- All NUM_REQ requesting continuously: every requester is granted at least once every ceil(NUM_REQ/2) cycles.

Test Plan:
- Reset, then requester 0 reads addr 0x0 → gnt=0001 same cycle; next cycle rsp_valid=0001, rsp_rdata[0]=FEEDFACECAFEBABE.
- Requester 1 writes 0xA=AAAA_AAAA_AAAA_AAAA, then reads 0xA → gnt each time; read response AAAA_AAAA_AAAA_AAAA; no rsp_valid for the write.
- Requesters 2 and 3 write 0x1=1111… and 0x2=2222… together → gnt=1100 in one cycle, both on different ports; reads back return matching values.
- Requesters 0 (write 0x5) and 1 (read 0x5) together, rr_ptr=0 → gnt=0001 first, 0010 next cycle; read returns the new data.
- All four requesters hold read req for 4 cycles, different addresses → grant pattern 0011, 1100, 0011, 1100; rsp_valid follows one cycle later with correct data routing.
- Assert reset in the cycle a read is granted → no rsp_valid the following cycle; rr_ptr=0; arbitration resumes cleanly after reset deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters, two grants per cycle.
// Latency: grant is combinational in the issue cycle; read data returns on rsp_* one cycle later.
// Backpressure: ungranted requesters simply hold req; same-address write hazards defer port B.
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int address_length = 4,
  parameter int word_length    = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*address_length-1:0] req_addr,
  input  logic [NUM_REQ*word_length-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [NUM_REQ*word_length-1:0]    rsp_rdata,
  output logic [address_length-1:0]         ram_address_a,
  output logic [address_length-1:0]         ram_address_b,
  output logic [word_length-1:0]            ram_data_a,
  output logic [word_length-1:0]            ram_data_b,
  output logic                              ram_wren_a,
  output logic                              ram_wren_b,
  input  logic [word_length-1:0]            ram_q_a,
  input  logic [word_length-1:0]            ram_q_b
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] rr_ptr;
  logic          vld_a, vld_b;
  logic [IW-1:0] own_a, own_b;

  logic          a_found, b_found;
  logic [IW-1:0] a_idx, b_idx, idx;

  // Scan from rr_ptr: first pending wins port A, next non-conflicting pending wins port B.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + IW'(k);
      if (!reset && req[idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = idx;
        end else if (!b_found &&
                     !((req_addr[idx*address_length +: address_length] ==
                        req_addr[a_idx*address_length +: address_length]) &&
                       (req_we[idx] || req_we[a_idx]))) begin
          b_found = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

  // Drive grants and RAM ports from the winners; idle ports are all-zero.
  always_comb begin
    gnt           = '0;
    ram_address_a = '0;
    ram_address_b = '0;
    ram_data_a    = '0;
    ram_data_b    = '0;
    ram_wren_a    = 1'b0;
    ram_wren_b    = 1'b0;
    if (a_found) begin
      gnt[a_idx]    = 1'b1;
      ram_address_a = req_addr[a_idx*address_length +: address_length];
      ram_data_a    = req_wdata[a_idx*word_length +: word_length];
      ram_wren_a    = req_we[a_idx];
    end
    if (b_found) begin
      gnt[b_idx]    = 1'b1;
      ram_address_b = req_addr[b_idx*address_length +: address_length];
      ram_data_b    = req_wdata[b_idx*word_length +: word_length];
      ram_wren_b    = req_we[b_idx];
    end
  end

  // Advance the pointer past the last requester granted; hold it when nothing was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (b_found) begin
      rr_ptr <= b_idx + 1'b1;
    end else if (a_found) begin
      rr_ptr <= a_idx + 1'b1;
    end
  end

  // Tag each port that carried a read so its RAM output can be routed back next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_a <= 1'b0;
      vld_b <= 1'b0;
      own_a <= '0;
      own_b <= '0;
    end else begin
      vld_a <= a_found && !req_we[a_idx];
      vld_b <= b_found && !req_we[b_idx];
      own_a <= a_idx;
      own_b <= b_idx;
    end
  end

  // Route registered RAM output to the owning requester; both ports never share an owner.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (vld_a) begin
      rsp_valid[own_a]                         = 1'b1;
      rsp_rdata[own_a*word_length +: word_length] = ram_q_a;
    end
    if (vld_b) begin
      rsp_valid[own_b]                         = 1'b1;
      rsp_rdata[own_b*word_length +: word_length] = ram_q_b;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-output dual-port RAM.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  logic [AW-1:0]   ram_address_a, ram_address_b;
  logic [DW-1:0]   ram_data_a, ram_data_b;
  logic            ram_wren_a, ram_wren_b;
  logic [DW-1:0]   ram_q_a, ram_q_b;

  logic [DW-1:0]   mem [16];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] FEED = 64'hFEEDFACECAFEBABE;
  localparam logic [63:0] VA   = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] V1   = 64'h1111111111111111;
  localparam logic [63:0] V2   = 64'h2222222222222222;
  localparam logic [63:0] V5   = 64'h5555555555555555;
  localparam logic [63:0] VD   = 64'hDEADDEADDEADDEAD;

  mem_port_arbiter #(.NUM_REQ(N), .address_length(AW), .word_length(DW)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // Registered-output RAM: writes and reads take effect on the rising edge.
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    ram_q_a <= mem[ram_address_a];
    ram_q_b <= mem[ram_address_b];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_req();
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  function automatic logic [63:0] rd(input int i);
    return rsp_rdata[i*DW +: DW];
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = FEED;
    ram_q_a = '0;
    ram_q_b = '0;
    reset = 1'b1;
    clr_req();
    cyc();
    cyc();

    // Requests presented during reset are ignored.
    set_req(0, 1'b1, 4'h3, VD);
    set_req(1, 1'b1, 4'h4, VD);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_wren_a", ram_wren_a, 0);
    chk("rst_wren_b", ram_wren_b, 0);
    chk("rst_addr_a", ram_address_a, 0);
    chk("rst_data_a", ram_data_a, 0);
    cyc();
    reset = 1'b0;
    clr_req();
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_rsp_rdata0", rd(0), 0);
    chk("post_rst_gnt", gnt, 0);

    // Single read from requester 0.
    cyc();
    set_req(0, 1'b0, 4'h0, '0);
    #1;
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_wren_a", ram_wren_a, 0);
    chk("t1_wren_b", ram_wren_b, 0);
    cyc();
    clr_req();
    #1;
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_rdata0", rd(0), FEED);

    // Requester 1 write then read back.
    cyc();
    set_req(1, 1'b1, 4'hA, VA);
    #1;
    chk("t2_wr_gnt", gnt, 4'b0010);
    chk("t2_wr_wren_a", ram_wren_a, 1);
    chk("t2_wr_addr_a", ram_address_a, 4'hA);
    chk("t2_wr_data_a", ram_data_a, VA);
    cyc();
    clr_req();
    set_req(1, 1'b0, 4'hA, '0);
    #1;
    chk("t2_wr_no_rsp", rsp_valid, 0);
    chk("t2_rd_gnt", gnt, 4'b0010);
    cyc();
    clr_req();
    #1;
    chk("t2_rsp_valid", rsp_valid, 4'b0010);
    chk("t2_rsp_rdata1", rd(1), VA);

    // Requesters 2 and 3 write together on both ports, then read back together.
    cyc();
    set_req(2, 1'b1, 4'h1, V1);
    set_req(3, 1'b1, 4'h2, V2);
    #1;
    chk("t3_wr_gnt", gnt, 4'b1100);
    chk("t3_addr_a", ram_address_a, 4'h1);
    chk("t3_data_a", ram_data_a, V1);
    chk("t3_addr_b", ram_address_b, 4'h2);
    chk("t3_data_b", ram_data_b, V2);
    chk("t3_wren_b", ram_wren_b, 1);
    cyc();
    clr_req();
    set_req(2, 1'b0, 4'h1, '0);
    set_req(3, 1'b0, 4'h2, '0);
    #1;
    chk("t3_rd_gnt", gnt, 4'b1100);
    chk("t3_wr_no_rsp", rsp_valid, 0);
    cyc();
    clr_req();
    #1;
    chk("t3_rsp_valid", rsp_valid, 4'b1100);
    chk("t3_rsp_rdata2", rd(2), V1);
    chk("t3_rsp_rdata3", rd(3), V2);

    // Write/read hazard on address 5: port B is held off, read follows and sees new data.
    cyc();
    set_req(0, 1'b1, 4'h5, V5);
    set_req(1, 1'b0, 4'h5, '0);
    #1;
    chk("t4_gnt_first", gnt, 4'b0001);
    chk("t4_wren_b_idle", ram_wren_b, 0);
    chk("t4_addr_b_idle", ram_address_b, 0);
    cyc();
    clr_req();
    set_req(1, 1'b0, 4'h5, '0);
    #1;
    chk("t4_gnt_second", gnt, 4'b0010);
    cyc();
    clr_req();
    #1;
    chk("t4_rsp_valid", rsp_valid, 4'b0010);
    chk("t4_rsp_rdata1", rd(1), V5);

    // Requester 3 alone always takes port A.
    cyc();
    set_req(3, 1'b0, 4'h0, '0);
    #1;
    chk("t4b_gnt", gnt, 4'b1000);
    chk("t4b_addr_a", ram_address_a, 4'h0);
    cyc();
    clr_req();
    #1;
    chk("t4b_rsp_valid", rsp_valid, 4'b1000);
    chk("t4b_rsp_rdata3", rd(3), FEED);
    cyc();

    // All four read continuously: pairs alternate, responses trail by one cycle.
    set_req(0, 1'b0, 4'h1, '0);
    set_req(1, 1'b0, 4'h2, '0);
    set_req(2, 1'b0, 4'hA, '0);
    set_req(3, 1'b0, 4'h5, '0);
    #1;
    chk("t5_c1_gnt", gnt, 4'b0011);
    chk("t5_c1_rsp", rsp_valid, 0);
    cyc();
    chk("t5_c2_gnt", gnt, 4'b1100);
    chk("t5_c2_rsp", rsp_valid, 4'b0011);
    chk("t5_c2_rd0", rd(0), V1);
    chk("t5_c2_rd1", rd(1), V2);
    cyc();
    chk("t5_c3_gnt", gnt, 4'b0011);
    chk("t5_c3_rsp", rsp_valid, 4'b1100);
    chk("t5_c3_rd2", rd(2), VA);
    chk("t5_c3_rd3", rd(3), V5);
    cyc();
    chk("t5_c4_gnt", gnt, 4'b1100);
    chk("t5_c4_rsp", rsp_valid, 4'b0011);
    cyc();
    clr_req();
    #1;
    chk("t5_c5_rsp", rsp_valid, 4'b1100);
    chk("t5_c5_rd0_zero", rd(0), 0);
    chk("t5_c5_rd3", rd(3), V5);

    // Move rr_ptr off zero, then reset while a read and a write are pending.
    cyc();
    set_req(0, 1'b0, 4'h0, '0);
    #1;
    chk("t6_pre_gnt", gnt, 4'b0001);
    cyc();
    clr_req();
    reset = 1'b1;
    set_req(2, 1'b0, 4'h1, '0);
    set_req(1, 1'b1, 4'h0, VD);
    #1;
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_wren_a", ram_wren_a, 0);
    chk("t6_rst_wren_b", ram_wren_b, 0);
    chk("t6_rst_prior_rsp", rsp_valid, 4'b0001);
    cyc();
    reset = 1'b0;
    clr_req();
    set_req(0, 1'b0, 4'h0, '0);
    set_req(1, 1'b0, 4'h1, '0);
    set_req(2, 1'b0, 4'h2, '0);
    set_req(3, 1'b0, 4'hA, '0);
    #1;
    chk("t6_post_rsp", rsp_valid, 0);
    chk("t6_post_gnt", gnt, 4'b0011);
    cyc();
    clr_req();
    #1;
    chk("t6_rsp_valid", rsp_valid, 4'b0011);
    chk("t6_rd0_no_write", rd(0), FEED);
    chk("t6_rd1", rd(1), V1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
